// File: rtl/bus_uart_tx.sv
// Bus-mapped UART transmitter: CPU register file, TX FIFO and 8N1 serializer.
// Bit period is PRESCALE*(DIV+1) clk; a new divisor is picked up only at a bit boundary.
module bus_uart_tx #(
  parameter int         PRESCALE  = 16,
  parameter logic [7:0] DIV_RESET = 8'd26,
  parameter int         FIFO_BITS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clken,
  input  logic       cs,
  input  logic [1:0] rs,
  input  logic       we,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       txd,
  output logic       irq
);

  localparam int                 DEPTH    = 1 << FIFO_BITS;
  localparam logic [FIFO_BITS:0] DEPTH_C  = (FIFO_BITS + 1)'(DEPTH);
  localparam int                 PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]      PRE_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [7:0]           r_mem [DEPTH];
  logic [FIFO_BITS-1:0] r_wptr;
  logic [FIFO_BITS-1:0] r_rptr;
  logic [FIFO_BITS:0]   r_count;
  logic                 r_ovf;
  logic                 r_tx_en;
  logic                 r_irq_en;
  logic [7:0]           r_div;
  logic [7:0]           r_div_bit;
  logic [PW-1:0]        r_pre;
  logic [7:0]           r_divcnt;
  logic [7:0]           r_shift;
  logic [2:0]           r_bitcnt;
  logic                 r_txd;
  logic                 r_irq;
  logic [7:0]           r_dout;

  logic       w_acc;
  logic       w_wr;
  logic       w_rd;
  logic       w_empty;
  logic       w_full;
  logic       w_push;
  logic       w_pop;
  logic       w_busy;
  logic       w_pre_wrap;
  logic       w_bit_end;
  logic [7:0] w_status;
  logic [7:0] w_rdata;

  assign w_acc      = cs && clken;
  assign w_wr       = w_acc && we;
  assign w_rd       = w_acc && !we;
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == DEPTH_C);
  assign w_push     = w_wr && (rs == 2'd0) && !w_full;
  assign w_busy     = (r_state != S_IDLE);
  assign w_pre_wrap = (r_pre == PRE_LAST);
  assign w_bit_end  = w_pre_wrap && (r_divcnt == r_div_bit);
  assign w_status   = {r_irq, 3'b000, r_ovf, w_busy, w_full, w_empty};

  assign dout = r_dout;
  assign txd  = r_txd;
  assign irq  = r_irq;

  always_comb begin
    w_rdata = 8'h00;
    case (rs)
      2'd1:    w_rdata = w_status;
      2'd2:    w_rdata = {6'b0, r_irq_en, r_tx_en};
      2'd3:    w_rdata = r_div;
      default: w_rdata = 8'h00;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_tx_en && !w_empty) begin
          w_state_nxt = S_START;
          w_pop       = 1'b1;
        end
      end
      S_START: if (w_bit_end) w_state_nxt = S_DATA;
      S_DATA:  if (w_bit_end && (r_bitcnt == 3'd7)) w_state_nxt = S_STOP;
      S_STOP:  if (w_bit_end) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Storage has no reset; emptiness is tracked by the pointers and count alone.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf    <= 1'b0;
      r_tx_en  <= 1'b1;
      r_irq_en <= 1'b0;
      r_div    <= DIV_RESET;
      r_dout   <= 8'h00;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr) begin
        case (rs)
          2'd0: if (w_full) r_ovf <= 1'b1;
          2'd1: r_ovf <= 1'b0;
          2'd2: begin
            r_tx_en  <= din[0];
            r_irq_en <= din[1];
          end
          default: r_div <= din;
        endcase
      end
      if (w_rd) r_dout <= w_rdata;
      r_irq <= r_irq_en && w_empty && !w_busy;
    end
  end

  // The divisor is latched per bit, so a DIV write mid-bit only affects later bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pre     <= '0;
      r_divcnt  <= 8'h00;
      r_div_bit <= 8'h00;
    end else if (r_state == S_IDLE) begin
      r_pre     <= '0;
      r_divcnt  <= 8'h00;
      r_div_bit <= r_div;
    end else if (w_bit_end) begin
      r_pre     <= '0;
      r_divcnt  <= 8'h00;
      r_div_bit <= r_div;
    end else if (w_pre_wrap) begin
      r_pre    <= '0;
      r_divcnt <= r_divcnt + 1'b1;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_txd    <= 1'b1;
      r_shift  <= 8'h00;
      r_bitcnt <= 3'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_shift  <= r_mem[r_rptr];
            r_bitcnt <= 3'd0;
            r_txd    <= 1'b0;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_txd   <= r_shift[0];
            r_shift <= {1'b0, r_shift[7:1]};
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            if (r_bitcnt == 3'd7) begin
              r_txd <= 1'b1;
            end else begin
              r_txd    <= r_shift[0];
              r_shift  <= {1'b0, r_shift[7:1]};
              r_bitcnt <= r_bitcnt + 1'b1;
            end
          end
        end
        default: r_txd <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_uart_tx.sv
// Directed bench for bus_uart_tx: framing, timing, FIFO overflow, irq, divisor update, reset and bus gating.
module tb_bus_uart_tx;

  logic       clk;
  logic       reset;
  logic       clken;
  logic       cs;
  logic [1:0] rs;
  logic       we;
  logic [7:0] din;
  logic [7:0] dout;
  logic       txd;
  logic       irq;

  int n_chk  = 0;
  int n_fail = 0;

  bus_uart_tx dut (
    .clk   (clk),
    .reset (reset),
    .clken (clken),
    .cs    (cs),
    .rs    (rs),
    .we    (we),
    .din   (din),
    .dout  (dout),
    .txd   (txd),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cs = 1'b1; clken = 1'b1; we = 1'b1; rs = a; din = d;
    tick();
    cs = 1'b0; clken = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    cs = 1'b1; clken = 1'b1; we = 1'b0; rs = a;
    tick();
    cs = 1'b0; clken = 1'b0;
    d = dout;
  endtask

  // Entered on the first cycle of the start bit; returns on the first IDLE cycle.
  task automatic frame(input logic [7:0] b, input string tag);
    logic e;
    for (int k = 0; k < 10; k++) begin
      if (k == 0)      e = 1'b0;
      else if (k == 9) e = 1'b1;
      else             e = b[k-1];
      chk($sformatf("%s_bit%0d_first", tag, k), {7'b0, txd}, {7'b0, e});
      repeat (15) @(posedge clk);
      #1;
      chk($sformatf("%s_bit%0d_last", tag, k), {7'b0, txd}, {7'b0, e});
      tick();
    end
  endtask

  task automatic wait_idle(input int max);
    logic [7:0] st;
    st = 8'hFF;
    for (int i = 0; i < max; i++) begin
      rd(2'd1, st);
      if (!st[2]) break;
    end
    chk("wait_idle_busy", {7'b0, st[2]}, 8'h00);
  endtask

  logic [7:0] v;

  initial begin
    reset = 1'b1; clken = 1'b0; cs = 1'b0; rs = 2'd0; we = 1'b0; din = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_txd", {7'b0, txd}, 8'h01);
    chk("rst_irq", {7'b0, irq}, 8'h00);
    chk("rst_dout", dout, 8'h00);
    reset = 1'b0;
    rd(2'd1, v); chk("rst_status", v, 8'h01);
    rd(2'd2, v); chk("rst_ctrl", v, 8'h01);
    rd(2'd3, v); chk("rst_div", v, 8'h1A);
    rd(2'd0, v); chk("rst_data", v, 8'h00);

    // Single frame at DIV=0, including first-transaction latency.
    wr(2'd3, 8'h00);
    wr(2'd0, 8'hA5);
    chk("a5_txd_at_write", {7'b0, txd}, 8'h01);
    tick();
    frame(8'hA5, "a5");
    rd(2'd1, v); chk("a5_status_idle", v, 8'h01);

    // Divisor change inside DATA bit 0.
    wr(2'd0, 8'hA5);
    tick();
    rd(2'd1, v); chk("div_status_busy", v, 8'h05);
    repeat (15) @(posedge clk);
    #1;
    chk("div_bit0_first", {7'b0, txd}, 8'h01);
    repeat (4) @(posedge clk);
    #1;
    wr(2'd3, 8'h01);
    repeat (10) @(posedge clk);
    #1;
    chk("div_bit0_last", {7'b0, txd}, 8'h01);
    tick();
    chk("div_bit1_first", {7'b0, txd}, 8'h00);
    repeat (31) @(posedge clk);
    #1;
    chk("div_bit1_last", {7'b0, txd}, 8'h00);
    tick();
    chk("div_bit2_first", {7'b0, txd}, 8'h01);
    wait_idle(400);
    wr(2'd3, 8'h00);

    // Overflow with TX disabled, then drain in order.
    wr(2'd2, 8'h00);
    for (int i = 0; i < 17; i++) wr(2'd0, 8'h10 + 8'(i));
    rd(2'd1, v); chk("ovf_status_full", v, 8'h0A);
    wr(2'd1, 8'hFF);
    rd(2'd1, v); chk("ovf_status_clr", v, 8'h02);
    wr(2'd2, 8'h01);
    tick();
    for (int i = 0; i < 16; i++) begin
      frame(8'h10 + 8'(i), $sformatf("fifo%0d", i));
      if (i < 15) tick();
    end
    rd(2'd1, v); chk("fifo_status_empty", v, 8'h01);
    repeat (20) @(posedge clk);
    #1;
    chk("fifo_no_extra", {7'b0, txd}, 8'h01);

    // Interrupt after the last queued frame.
    wr(2'd2, 8'h03);
    wr(2'd0, 8'h55);
    wr(2'd0, 8'h81);
    chk("irq_frame1_start", {7'b0, irq}, 8'h00);
    frame(8'h55, "irq1");
    chk("irq_gap", {7'b0, irq}, 8'h00);
    tick();
    chk("irq_frame2_start", {7'b0, irq}, 8'h00);
    frame(8'h81, "irq2");
    chk("irq_stop_end", {7'b0, irq}, 8'h00);
    tick();
    chk("irq_asserted", {7'b0, irq}, 8'h01);
    rd(2'd1, v); chk("irq_status", v, 8'h81);
    wr(2'd2, 8'h01);

    // Bus activity without clken must be ignored.
    rd(2'd2, v); chk("gate_ctrl_pre", v, 8'h01);
    for (int i = 0; i < 8; i++) begin
      cs = 1'b1; clken = 1'b0; we = (i < 4); rs = 2'(i); din = 8'h5A;
      tick();
    end
    cs = 1'b0; we = 1'b0;
    chk("gate_dout", dout, 8'h01);
    chk("gate_txd", {7'b0, txd}, 8'h01);
    rd(2'd1, v); chk("gate_status", v, 8'h01);
    rd(2'd2, v); chk("gate_ctrl", v, 8'h01);
    rd(2'd3, v); chk("gate_div", v, 8'h00);

    // Reset in the middle of DATA bit 4 with bytes queued.
    wr(2'd0, 8'h0F);
    wr(2'd0, 8'h22);
    wr(2'd0, 8'h33);
    wr(2'd0, 8'h44);
    repeat (82) @(posedge clk);
    #1;
    chk("mid_bit4", {7'b0, txd}, 8'h00);
    reset = 1'b1;
    tick();
    chk("mid_rst_txd", {7'b0, txd}, 8'h01);
    chk("mid_rst_dout", dout, 8'h00);
    chk("mid_rst_irq", {7'b0, irq}, 8'h00);
    reset = 1'b0;
    rd(2'd1, v); chk("mid_status", v, 8'h01);
    rd(2'd2, v); chk("mid_ctrl", v, 8'h01);
    rd(2'd3, v); chk("mid_div", v, 8'h1A);
    repeat (10) @(posedge clk);
    #1;
    chk("mid_discarded", {7'b0, txd}, 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
